// File: rtl/ni_axil_pkg.sv
// Shared types and AXI4-Lite constants for the network-interface request arbiter.
package ni_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_AW_W,
        ST_WR_B,
        ST_RD_AR,
        ST_RD_R,
        ST_DONE
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT  = 3'b000;
    localparam logic [3:0] AXI_WSTRB = 4'hF;

    // (a + b) mod n for small non-negative operands (b < n)
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/ni_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from ptr, with wrap.
module ni_rr_arbiter
    import ni_axil_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest set bit to ptr wins last.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'(wrap_add(int'(ptr), i, NUM_REQ));
            if (req[cand]) begin
                gnt_idx = cand;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ni_axil_req_arbiter.sv
// Shares one AXI4-Lite master port among NUM_REQ requesters, one single-beat access at a time.
module ni_axil_req_arbiter
    import ni_axil_pkg::*;
#(
    parameter int               NUM_REQ   = 4,
    parameter int               ADDR_W    = 32,
    parameter int               DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      busy,
    output logic [ADDR_W-1:0]         m_awaddr,
    output logic [2:0]                m_awprot,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DATA_W-1:0]         m_wdata,
    output logic [3:0]                m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [ADDR_W-1:0]         m_araddr,
    output logic [2:0]                m_arprot,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e                           state;
    logic [IDX_W-1:0]                 rr_ptr, gnt_q, arb_idx;
    logic                             arb_vld;
    logic [ADDR_W-1:0]                addr_q;
    logic [DATA_W-1:0]                wdata_q;
    logic [NUM_REQ-1:0][ADDR_W-1:0]   addr_v;
    logic [NUM_REQ-1:0][DATA_W-1:0]   wdata_v;
    logic                             aw_fin, w_fin;

    assign addr_v  = req_addr;
    assign wdata_v = req_wdata;

    ni_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // A channel is finished once its valid has dropped or it handshakes this cycle.
    assign aw_fin = !m_awvalid || m_awready;
    assign w_fin  = !m_wvalid  || m_wready;

    assign m_awaddr = addr_q;
    assign m_araddr = addr_q;
    assign m_wdata  = wdata_q;
    assign m_awprot = AXI_PROT;
    assign m_arprot = AXI_PROT;
    assign m_wstrb  = AXI_WSTRB;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            gnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            done      <= '0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (arb_vld) begin
                    gnt_q   <= arb_idx;
                    addr_q  <= BASE_ADDR + addr_v[arb_idx];
                    wdata_q <= wdata_v[arb_idx];
                    if (req_we[arb_idx]) begin
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        state     <= ST_WR_AW_W;
                    end else begin
                        m_arvalid <= 1'b1;
                        state     <= ST_RD_AR;
                    end
                end
                ST_WR_AW_W: begin
                    if (m_awready) m_awvalid <= 1'b0;
                    if (m_wready)  m_wvalid  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        m_bready <= 1'b1;
                        state    <= ST_WR_B;
                    end
                end
                ST_WR_B: if (m_bvalid) begin
                    m_bready <= 1'b0;
                    rsp_resp <= m_bresp;
                    done     <= NUM_REQ'(1) << gnt_q;
                    state    <= ST_DONE;
                end
                ST_RD_AR: if (m_arready) begin
                    m_arvalid <= 1'b0;
                    m_rready  <= 1'b1;
                    state     <= ST_RD_R;
                end
                ST_RD_R: if (m_rvalid) begin
                    m_rready  <= 1'b0;
                    rsp_rdata <= m_rdata;
                    rsp_resp  <= m_rresp;
                    done      <= NUM_REQ'(1) << gnt_q;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    done   <= '0;
                    rr_ptr <= IDX_W'(wrap_add(int'(gnt_q), 1, NUM_REQ));
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ni_axil_req_arbiter.md
Name: ni_axil_req_arbiter

Overview:
- Shares the single AXI4-Lite master port of the network_interface register block between N local requesters (PE traffic generator, config loader, stats poller, ...).
- Each requester issues one 32-bit register read or write over a simple req/done handshake.
- The block round-robin arbitrates, sequences the AXI4-Lite channels (AW/W concurrent, then B; or AR then R), and returns data and response to the winner.
- Sits between the requesters and the network_interface S00_AXI slave.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width (fixed 32; WSTRB all ones)
- BASE_ADDR, 32'h0000_0000, added to every requester address before issue

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester request; held high until its done pulse
- req_we  in  NUM_REQ  1 = write, 0 = read; sampled at grant
- req_addr  in  NUM_REQ*ADDR_W  flattened byte offsets, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  flattened write data
- done  out  NUM_REQ  one-cycle pulse to the served requester
- rsp_rdata  out  DATA_W  read data, valid in the done cycle
- rsp_resp  out  2  BRESP/RRESP of the completed access, valid in the done cycle
- busy  out  1  high from grant until the done cycle inclusive
- m_awaddr  out  ADDR_W  AXI write address
- m_awprot  out  3  constant 3'b000
- m_awvalid  out  1  AXI write address valid
- m_awready  in  1  AXI write address ready
- m_wdata  out  DATA_W  AXI write data
- m_wstrb  out  4  constant 4'hF
- m_wvalid  out  1  AXI write data valid
- m_wready  in  1  AXI write data ready
- m_bresp  in  2  AXI write response
- m_bvalid  in  1  AXI write response valid
- m_bready  out  1  AXI write response ready
- m_araddr  out  ADDR_W  AXI read address
- m_arprot  out  3  constant 3'b000
- m_arvalid  out  1  AXI read address valid
- m_arready  in  1  AXI read address ready
- m_rdata  in  DATA_W  AXI read data
- m_rresp  in  2  AXI read response
- m_rvalid  in  1  AXI read data valid
- m_rready  out  1  AXI read data ready

Behaviour:
- Reset (ARESETN low, asynchronous): state IDLE; all valid/ready outputs, done and busy 0; rsp_rdata 0; rsp_resp 0; rr pointer 0; grant index 0. Reset mid-transaction abandons it silently; no done is issued.
- FSM states:
  - IDLE: if any req bit is set, pick the first set bit scanning from rr_ptr upward with wrap. Latch index, we, BASE_ADDR+addr (modulo 2^ADDR_W) and wdata. Go to WR_AW_W if we=1, else RD_AR. Grant takes 1 cycle; valids assert the cycle after the grant decision.
  - WR_AW_W: awvalid and wvalid asserted together. Each drops independently after its own handshake (aw_done/w_done flags). Same-cycle or any-order acceptance is legal. When both flags are set (counting a handshake in the current cycle), go to WR_B.
  - WR_B: bready=1. On bvalid, capture bresp; rsp_rdata unchanged. Go to DONE.
  - RD_AR: arvalid=1 until arready, then RD_R.
  - RD_R: rready=1. On rvalid, capture rdata and rresp. Go to DONE.
  - DONE: pulse done[grant] for 1 cycle; rr_ptr = grant+1 (wrap at NUM_REQ); return to IDLE.
- Arbitration is evaluated only in IDLE. A requester re-asserting req in the cycle after its done is served again only after the others in rr order.
- Latency with an always-ready slave (zero-wait: ready high, response in the cycle after address): write and read each complete in 4 cycles from req-high to done; back-to-back transactions have 1 idle cycle between them.
- AXI rules: valid never depends on ready combinationally; address and data stay stable while valid && !ready; no outstanding transactions (one at a time).
- Non-OKAY responses (SLVERR/DECERR) are passed through on rsp_resp with no retry.
- Dropping req before done is a protocol violation; the transaction still completes and done still pulses.
- busy = (state != IDLE).

Decomposition:
- Shared package ni_axil_pkg:
  - state enum encoding
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants
  - AXI prot and strobe constants
- One sub-module: ni_rr_arbiter. Combinational first-set-from-pointer priority pick with a valid output, parameterised by NUM_REQ; reusable by other NoC arbiters.

Test Plan:
- Single write: req[0] we=1 addr 0x4 wdata 0xABCD0001, zero-wait slave -> one AW at BASE+0x4 with W 0xABCD0001, WSTRB F, done[0] 4 cycles after req, rsp_resp 00.
- Single read: req[2] addr 0x8, slave returns 0xDEAD0011 -> AR 0x8, done[2] with rsp_rdata 0xDEAD0011, rsp_resp 00.
- Fairness: all 4 req held high continuously -> grant order 0,1,2,3,0,1... over 8 transactions; no requester served twice consecutively.
- Skewed handshake: awready delayed 3 cycles, wready immediate -> wvalid drops after 1 beat, awvalid held stable 3 cycles, exactly one B accepted, done once.
- Error pass-through: slave returns BRESP 10 on write from req[1] -> done[1] with rsp_resp 10; the next transaction proceeds normally.
- Reset mid-read: ARESETN low while in RD_R -> all outputs 0 immediately; after release, IDLE with rr_ptr 0 and no spurious done.
